snn_tick_scheduler: RTL and testbench

SNN_TICK_SCHEDULER -- requirements
Module: snn_tick_scheduler

---
 rtl/snn_tick_scheduler_if.sv | 37 +++
 rtl/snn_tick_scheduler.sv | 153 +++++++++++++++
 tb/tb_snn_tick_scheduler.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/snn_tick_scheduler_if.sv
// ============================================================================
// Module   : snn_tick_scheduler_if
// Purpose  : Update-request, spike-event and status bundle of the SNN tick
//            scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface snn_tick_scheduler_if #(
    parameter int IDX_W = 2
);
    logic             enable;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_ready;
    logic             upd_done;
    logic             upd_spike;
    logic             ev_valid;
    logic [IDX_W-1:0] ev_idx;
    logic             ev_ready;
    logic             busy;
    logic             overrun;
    logic             ev_drop;
    logic [7:0]       step_count;

    modport master (
        input  enable, upd_ready, upd_done, upd_spike, ev_ready,
        output upd_valid, upd_idx, ev_valid, ev_idx, busy, overrun, ev_drop, step_count
    );

    modport slave (
        output enable, upd_ready, upd_done, upd_spike, ev_ready,
        input  upd_valid, upd_idx, ev_valid, ev_idx, busy, overrun, ev_drop, step_count
    );
endinterface

`default_nettype wire

// File: rtl/snn_tick_scheduler.sv
// ============================================================================
// Module   : snn_tick_scheduler
// Purpose  : Timestep generator that sweeps N_NEURONS through a shared LIF/STDP
//            datapath and queues the resulting spike events.
// Revision : 1.0
// ============================================================================
`default_nettype none

module snn_tick_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int IDX_W     = 2,
    parameter int TICK_DIV  = 16,
    parameter int EV_DEPTH  = 4
) (
    input  wire logic              clk,
    input  wire logic              reset,
    snn_tick_scheduler_if.master   bus
);

    localparam int c_TCW = $clog2(TICK_DIV);
    localparam int c_PW  = $clog2(EV_DEPTH);
    localparam int c_CW  = c_PW + 1;

    localparam logic [c_TCW-1:0] c_TICK_LAST = c_TCW'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST  = IDX_W'(N_NEURONS - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_NEXT  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [c_TCW-1:0] r_tick_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_step;
    logic             r_overrun;
    logic             r_drop;
    logic [IDX_W-1:0] r_mem [EV_DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic w_tick;
    logic w_upd_valid;
    logic w_busy;
    logic w_last;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;

    assign w_tick = bus.enable && (r_tick_cnt == c_TICK_LAST);
    assign w_last = (r_idx == c_IDX_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (bus.enable) begin
            r_tick_cnt <= (r_tick_cnt == c_TICK_LAST) ? '0 : r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:  if (w_tick)        w_next_state = c_S_ISSUE;
            c_S_ISSUE: if (bus.upd_ready) w_next_state = c_S_WAIT;
            c_S_WAIT:  if (bus.upd_done)  w_next_state = c_S_NEXT;
            c_S_NEXT:  w_next_state = w_last ? c_S_IDLE : c_S_ISSUE;
            default:   w_next_state = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_upd_valid = (r_state == c_S_ISSUE);
        w_busy      = (r_state != c_S_IDLE);
    end

    // A tick that lands mid-sweep is flagged and then simply dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx     <= '0;
            r_step    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (r_state == c_S_IDLE && w_tick) begin
                r_idx <= '0;
            end else if (r_state == c_S_NEXT && !w_last) begin
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == c_S_NEXT && w_last) begin
                r_step <= r_step + 1'b1;
            end
            if (w_tick && w_busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign w_empty    = (r_count == '0);
    assign w_full     = r_count[c_CW-1];
    assign w_pop      = bus.ev_ready && !w_empty;
    assign w_push_req = (r_state == c_S_WAIT) && bus.upd_done && bus.upd_spike;
    assign w_push     = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_push_req && w_full && !w_pop) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign bus.upd_valid  = w_upd_valid;
    assign bus.upd_idx    = r_idx;
    assign bus.busy       = w_busy;
    assign bus.overrun    = r_overrun;
    assign bus.ev_drop    = r_drop;
    assign bus.step_count = r_step;
    assign bus.ev_valid   = !w_empty;
    assign bus.ev_idx     = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: tb/tb_snn_tick_scheduler.sv
// ============================================================================
// Module   : tb_snn_tick_scheduler
// Purpose  : Directed and randomized sweeps checked against a queue-based
//            event model and sweep/step bookkeeping.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_snn_tick_scheduler;

    localparam int N  = 4;
    localparam int TD = 16;
    localparam int DP = 4;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   busy_cnt = 0;
    int   steps    = 0;
    bit   exp_drop = 0;
    int   q[$];

    snn_tick_scheduler_if #(.IDX_W(2)) bus ();

    snn_tick_scheduler #(
        .N_NEURONS(N), .IDX_W(2), .TICK_DIV(TD), .EV_DEPTH(DP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.busy === 1'b1) busy_cnt++;
    endtask

    // One full sweep acting as the datapath; per-neuron stall/latency in bytes.
    task automatic sweep(input logic [3:0] mask, input logic [31:0] rdel,
                         input logic [31:0] ddel, input bit hold_en,
                         input bit pop_on_done, input bit stray);
        int  n;
        bit  pop;
        bus.enable = 1'b1;
        n = 0;
        while (bus.upd_valid !== 1'b1 && n < 3*TD) begin
            cyc();
            n++;
        end
        chk("sweep_start", bus.upd_valid, 1);
        busy_cnt = 1;
        if (!hold_en) bus.enable = 1'b0;
        for (int i = 0; i < N; i++) begin
            chk("issue_valid", bus.upd_valid, 1);
            chk("issue_idx", bus.upd_idx, i);
            for (int d = 0; d < int'(rdel[8*i +: 8]); d++) begin
                bus.upd_ready = 1'b0;
                if (stray) begin
                    bus.upd_done  = 1'($urandom_range(0, 1));
                    bus.upd_spike = 1'b1;
                end
                cyc();
                bus.upd_done  = 1'b0;
                bus.upd_spike = 1'b0;
                chk("stall_valid", bus.upd_valid, 1);
                chk("stall_idx", bus.upd_idx, i);
            end
            bus.upd_ready = 1'b1;
            cyc();
            bus.upd_ready = 1'b0;
            chk("xfer_to_wait", bus.upd_valid, 0);
            for (int d = 0; d < int'(ddel[8*i +: 8]); d++) cyc();
            bus.upd_done  = 1'b1;
            bus.upd_spike = mask[i];
            bus.ev_ready  = pop_on_done;
            pop = pop_on_done && (q.size() > 0);
            cyc();
            bus.upd_done  = 1'b0;
            bus.upd_spike = 1'b0;
            bus.ev_ready  = 1'b0;
            if (pop) void'(q.pop_front());
            if (mask[i]) begin
                if (q.size() < DP) q.push_back(i);
                else               exp_drop = 1'b1;
            end
            chk("ev_drop", bus.ev_drop, exp_drop);
            chk("ev_valid", bus.ev_valid, (q.size() != 0));
            if (i == N-1) bus.enable = 1'b0;
            cyc();
        end
        steps++;
        chk("sweep_end_busy", bus.busy, 0);
        chk("step_count", bus.step_count, steps % 256);
    endtask

    task automatic drain();
        int g = 0;
        bus.ev_ready = 1'b1;
        while (q.size() > 0 && g < 2*DP + 2) begin
            chk("pop_valid", bus.ev_valid, 1);
            chk("pop_idx", bus.ev_idx, q[0]);
            cyc();
            void'(q.pop_front());
            g++;
        end
        chk("fifo_empty", bus.ev_valid, 0);
        bus.ev_ready = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.enable = 1'b0; bus.upd_ready = 1'b0; bus.upd_done = 1'b0;
        bus.upd_spike = 1'b0; bus.ev_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_upd_valid", bus.upd_valid, 0);
        chk("rst_upd_idx", bus.upd_idx, 0);
        chk("rst_ev_valid", bus.ev_valid, 0);
        chk("rst_ev_idx", bus.ev_idx, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_ev_drop", bus.ev_drop, 0);
        chk("rst_step", bus.step_count, 0);
        reset = 1'b0;

        // Basic sweep with enable held: 12 busy cycles, events 1 then 3.
        sweep(4'b1010, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("basic_busy_cycles", busy_cnt, 3*N);
        chk("basic_overrun", bus.overrun, 0);
        drain();

        // Backpressure: five stall cycles on neuron 1 with stray done pulses.
        sweep(4'b0110, 32'h0000_0500, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("bp_busy_cycles", busy_cnt, 3*N + 5);
        drain();

        // Full FIFO with a pop alongside every push: nothing is lost.
        sweep(4'b1111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        sweep(4'b1111, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("full_pop_no_drop", bus.ev_drop, 0);
        drain();

        while (steps < 256) begin
            sweep(4'($urandom), $urandom & 32'h0303_0303, $urandom & 32'h0303_0303,
                  1'b0, 1'($urandom_range(0, 1)), 1'b1);
            drain();
        end
        chk("wrap_step", bus.step_count, 0);
        chk("wrap_overrun", bus.overrun, 0);
        chk("wrap_ev_drop", bus.ev_drop, 0);

        // Two full-spike sweeps with no consumer: second batch dropped.
        sweep(4'b1111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        sweep(4'b1111, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("drop_set", bus.ev_drop, 1);
        chk("drop_count_held", q.size(), DP);
        drain();

        // Withheld upd_done spans a tick: overrun, sweep still completes.
        sweep(4'b0000, 32'h0, 32'd20, 1'b1, 1'b0, 1'b0);
        chk("overrun_set", bus.overrun, 1);
        repeat (20) cyc();
        chk("overrun_tick_discarded", bus.busy, 0);

        // Reset during WAIT on neuron 2 after two events were queued.
        bus.enable = 1'b1;
        n = 0;
        while (bus.upd_valid !== 1'b1 && n < 3*TD) begin cyc(); n++; end
        bus.enable = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.upd_ready = 1'b1; cyc(); bus.upd_ready = 1'b0;
            bus.upd_done = 1'b1; bus.upd_spike = 1'b1; cyc();
            bus.upd_done = 1'b0; bus.upd_spike = 1'b0; cyc();
        end
        bus.upd_ready = 1'b1; cyc(); bus.upd_ready = 1'b0;
        chk("pre_rst_ev_valid", bus.ev_valid, 1);
        chk("pre_rst_idx", bus.upd_idx, 2);
        reset = 1'b1;
        #1;
        chk("arst_upd_valid", bus.upd_valid, 0);
        chk("arst_upd_idx", bus.upd_idx, 0);
        chk("arst_ev_valid", bus.ev_valid, 0);
        chk("arst_ev_idx", bus.ev_idx, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_overrun", bus.overrun, 0);
        chk("arst_ev_drop", bus.ev_drop, 0);
        chk("arst_step", bus.step_count, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        q.delete();
        bus.upd_done = 1'b1; bus.upd_spike = 1'b1;
        cyc();
        bus.upd_done = 1'b0; bus.upd_spike = 1'b0;
        chk("late_done_no_event", bus.ev_valid, 0);
        chk("late_done_idle", bus.busy, 0);
        bus.enable = 1'b1;
        n = 0;
        while (bus.upd_valid !== 1'b1 && n < 3*TD) begin cyc(); n++; end
        chk("first_tick_after_reset", n, TD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
